// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// ------------------------------------------------------------------------
// Decode-stage immediate generator with one register stage. For each
// accepted RV32/RV64 instruction it produces the sign-extended immediate,
// a format code, the PC-relative target (pc + imm, wrapping silently) and
// an "unknown opcode" flag. Results leave in strict FIFO order through a
// main output register backed by one skid entry.
//
// Ports:
//   clk        core clock, rising-edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush; discards both entries and the input
//   in_valid   upstream presents in_inst / in_pc
//   in_ready   block can take an instruction this cycle
//   in_inst    32-bit instruction word
//   in_pc      XLEN-bit instruction address
//   out_valid  out_* carry a result
//   out_ready  downstream takes the result
//   out_imm    extended immediate
//   out_fmt    0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH
//   out_tgt    in_pc + out_imm modulo 2^XLEN
//   out_unk    opcode not recognised
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is registered state (skid entry empty) and never
// depends combinationally on out_ready. While out_valid=1 and
// out_ready=0 every out_* field is held stable.
// ------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_tgt,
    output logic            out_unk
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    // ---------------- combinational decode ----------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [31:0]     i_raw;
    logic [31:0]     raw;        // immediate as a 32-bit signed quantity
    logic [2:0]      dec_fmt;
    logic            dec_unk;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_tgt;

    always_comb begin
        opcode   = in_inst[6:0];
        funct3   = in_inst[14:12];
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        i_raw    = {{20{in_inst[31]}}, in_inst[31:20]};
        raw      = '0;
        dec_fmt  = FMT_NONE;
        dec_unk  = 1'b0;

        case (opcode)
            7'b0010011: begin
                if (is_shift) begin
                    // funct7/funct6 bits above the shamt are masked off
                    dec_fmt = FMT_SH;
                    raw     = (XLEN == 64) ? {26'b0, in_inst[25:20]}
                                           : {27'b0, in_inst[24:20]};
                end else begin
                    dec_fmt = FMT_I;
                    raw     = i_raw;
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                raw     = i_raw;
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64; word shifts use 5-bit shamt
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_fmt = FMT_SH;
                        raw     = {27'b0, in_inst[24:20]};
                    end else begin
                        dec_fmt = FMT_I;
                        raw     = i_raw;
                    end
                end else begin
                    dec_unk = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                raw     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                raw     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                raw     = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                raw     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            7'b0110011: begin
                // register-register ops: known, no immediate
            end
            7'b0111011: begin
                dec_unk = (XLEN != 64);
            end
            default: begin
                dec_unk = 1'b1;
            end
        endcase

        // raw is signed 32-bit; widening to XLEN replicates bit 31
        dec_imm = XLEN'($signed(raw));
        dec_tgt = in_pc + dec_imm;
    end

    // ---------------- main register + skid entry ----------------
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic [XLEN-1:0] skid_tgt;
    logic            skid_unk;
    logic            accept;
    logic            fire;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;
    assign fire     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= FMT_NONE;
            out_tgt    <= '0;
            out_unk    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_tgt   <= '0;
            skid_unk   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid && fire) begin
            // older skid entry moves up; in_ready was low so no accept
            out_imm    <= skid_imm;
            out_fmt    <= skid_fmt;
            out_tgt    <= skid_tgt;
            out_unk    <= skid_unk;
            skid_valid <= 1'b0;
        end else if (accept && (!out_valid || fire)) begin
            out_valid  <= 1'b1;
            out_imm    <= dec_imm;
            out_fmt    <= dec_fmt;
            out_tgt    <= dec_tgt;
            out_unk    <= dec_unk;
        end else if (accept) begin
            // main is stalled: park the new result behind it
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_tgt   <= dec_tgt;
            skid_unk   <= dec_unk;
        end else if (fire) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe. Two instances (XLEN=32 and XLEN=64) share
// the same stimulus; a reference model decodes immediates with plain
// arithmetic and a queue of accepted {pc, inst} pairs tracks occupancy
// and result order.
module tb_imm_gen_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;

    logic        in_ready32, out_valid32, out_unk32;
    logic [31:0] out_imm32, out_tgt32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_unk64;
    logic [63:0] out_imm64, out_tgt64;
    logic [2:0]  out_fmt64;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_tgt(out_tgt32), .out_unk(out_unk32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_tgt(out_tgt64), .out_unk(out_unk64)
    );

    int checks = 0;
    int failures = 0;
    logic [95:0] exp_q[$];   // {pc[63:0], inst[31:0]} in acceptance order

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic void ref_model(input int xlen, input logic [31:0] inst, input logic [63:0] pc,
                                      output logic [63:0] imm, output logic [63:0] tgt,
                                      output logic [2:0] fmt, output logic unk);
        longint w, v;
        int op, f3;
        logic [63:0] mask;
        w   = longint'(inst);
        op  = int'(w & 127);
        f3  = int'((w >> 12) & 7);
        v   = 0;
        fmt = 3'd0;
        unk = 1'b0;
        case (op)
            'h13: if (f3 == 1 || f3 == 5) begin fmt = 3'd6; v = (w >> 20) & ((xlen == 64) ? 63 : 31); end
                  else begin fmt = 3'd1; v = sext(w >> 20, 12); end
            'h03, 'h67, 'h73: begin fmt = 3'd1; v = sext(w >> 20, 12); end
            'h1B: if (xlen != 64) unk = 1'b1;
                  else if (f3 == 1 || f3 == 5) begin fmt = 3'd6; v = (w >> 20) & 31; end
                  else begin fmt = 3'd1; v = sext(w >> 20, 12); end
            'h23: begin fmt = 3'd2; v = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12); end
            'h63: begin
                fmt = 3'd3;
                v = sext(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048 +
                         ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2, 13);
            end
            'h37, 'h17: begin fmt = 3'd4; v = sext(w & 'hFFFFF000, 32); end
            'h6F: begin
                fmt = 3'd5;
                v = sext(((w >> 31) & 1) * (1 << 20) + ((w >> 12) & 255) * (1 << 12) +
                         ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2, 21);
            end
            'h33: ;
            'h3B: unk = (xlen != 64);
            default: unk = 1'b1;
        endcase
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        imm = 64'(v) & mask;
        tgt = (pc + 64'(v)) & mask;
    endfunction

    task automatic check_head(input logic [95:0] e);
        logic [63:0] imm, tgt;
        logic [2:0] fmt;
        logic unk;
        ref_model(32, e[31:0], e[95:32], imm, tgt, fmt, unk);
        check_eq("imm32", out_imm32, imm);
        check_eq("tgt32", out_tgt32, tgt);
        check_eq("fmt32", out_fmt32, fmt);
        check_eq("unk32", out_unk32, unk);
        ref_model(64, e[31:0], e[95:32], imm, tgt, fmt, unk);
        check_eq("imm64", out_imm64, imm);
        check_eq("tgt64", out_tgt64, tgt);
        check_eq("fmt64", out_fmt64, fmt);
        check_eq("unk64", out_unk64, unk);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid32"}, out_valid32, 0);
        check_eq({tag, "_imm32"},   out_imm32, 0);
        check_eq({tag, "_fmt32"},   out_fmt32, 0);
        check_eq({tag, "_tgt32"},   out_tgt32, 0);
        check_eq({tag, "_unk32"},   out_unk32, 0);
        check_eq({tag, "_ready32"}, in_ready32, 1);
        check_eq({tag, "_valid64"}, out_valid64, 0);
        check_eq({tag, "_imm64"},   out_imm64, 0);
        check_eq({tag, "_tgt64"},   out_tgt64, 0);
        check_eq({tag, "_ready64"}, in_ready64, 1);
    endtask

    // ---------------- scoreboard (samples on falling edge) ----------------
    always @(negedge clk) begin
        int n;
        if (!rst_n) begin
            exp_q.delete();
            check_zero("rst_hold");
        end else begin
            n = exp_q.size();
            check_eq("in_ready32", in_ready32, (n < 2) ? 1 : 0);
            check_eq("in_ready64", in_ready64, (n < 2) ? 1 : 0);
            check_eq("out_valid32", out_valid32, (n > 0) ? 1 : 0);
            check_eq("out_valid64", out_valid64, (n > 0) ? 1 : 0);
            if (n > 0) check_head(exp_q[0]);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (n > 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && n < 2) exp_q.push_back({in_pc, in_inst});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready32) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input bit sel64, input logic [31:0] inst,
                            input logic [63:0] pc, input logic [2:0] fmt, input logic [63:0] imm,
                            input logic [63:0] tgt, input logic unk);
        send(inst, pc);
        if (sel64) begin
            check_eq({tag, "_valid"}, out_valid64, 1);
            check_eq({tag, "_fmt"},   out_fmt64, fmt);
            check_eq({tag, "_imm"},   out_imm64, imm);
            check_eq({tag, "_tgt"},   out_tgt64, tgt);
            check_eq({tag, "_unk"},   out_unk64, unk);
        end else begin
            check_eq({tag, "_valid"}, out_valid32, 1);
            check_eq({tag, "_fmt"},   out_fmt32, fmt);
            check_eq({tag, "_imm"},   out_imm32, imm);
            check_eq({tag, "_tgt"},   out_tgt32, tgt);
            check_eq({tag, "_unk"},   out_unk32, unk);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 13);
        if (k < 12) r[6:0] = ops[k];
        return r;
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [31:0] hi, lo;
        hi = $urandom();
        lo = $urandom();
        return {hi, lo};
    endfunction

    task automatic rand_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_inst   = rand_inst();
            in_pc     = rand_pc();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");

        out_ready = 1'b1;
        directed("addi",   0, 32'hFFF00093, 64'h100, 3'd1, 64'hFFFFFFFF, 64'h000000FF, 0);
        directed("sw",     0, 32'hFE20AE23, 64'h0,   3'd2, 64'hFFFFFFFC, 64'hFFFFFFFC, 0);
        directed("slli",   0, 32'h01F09093, 64'h0,   3'd6, 64'h1F, 64'h1F, 0);
        directed("srai",   0, 32'h41F0D093, 64'h0,   3'd6, 64'h1F, 64'h1F, 0);
        directed("jal",    0, 32'h001000EF, 64'hFFFFF900, 3'd5, 64'h800, 64'h100, 0);
        directed("lui64",  1, 32'h800002B7, 64'h0,   3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 0);
        directed("unk64",  1, 32'h0000007F, 64'h100, 3'd0, 64'h0, 64'h100, 1);
        directed("slli63", 1, 32'h03F09093, 64'h0,   3'd6, 64'h3F, 64'h3F, 0);
        @(posedge clk); #1;

        // backpressure: two accepted, third waits until the skid drains
        out_ready = 1'b0;
        send(32'h00500113, 64'h200);
        send(32'h00A00193, 64'h204);
        in_valid = 1'b1;
        in_inst  = 32'h00F00213;
        in_pc    = 64'h208;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready32, 0);
            check_eq("bp_out_valid", out_valid32, 1);
            check_eq("bp_imm_first", out_imm32, 64'h5);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (in_ready32) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("bp_third_accept", ok, 1);
        repeat (4) @(posedge clk);
        #1;

        // flush with both entries full and an input presented
        out_ready = 1'b0;
        send(32'h00100293, 64'h300);
        send(32'h00200313, 64'h304);
        in_valid = 1'b1;
        in_inst  = 32'h00300393;
        in_pc    = 64'h308;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", out_valid32, 0);
        check_eq("flush_in_ready", in_ready32, 1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // asynchronous reset with entries in flight
        out_ready = 1'b0;
        send(32'hFFF00093, 64'h400);
        send(32'h001000EF, 64'h404);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        rand_phase(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
